// File: rtl/unified_mem_arbiter_if.sv
// Signal bundle between the core's fetch/load-store ports, the arbiter and the shared RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port synchronous RAM:
// data-port priority, bounded fetch starvation, one outstanding read at a time.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    unified_mem_arbiter_if.slave bus
);
    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [SCNT_W-1:0] starve_cnt;
    logic              owner_d;

    logic              gnt_i;
    logic              gnt_d;
    logic              d_misaligned;
    logic              rd_start;
    logic              rd_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              i_rvalid;
    logic              d_rvalid;
    logic              d_err;
    logic [DATA_W-1:0] i_rdata;
    logic [DATA_W-1:0] d_rdata;

    logic              unused_fetch_low;

    // Fetches are word aligned by truncation, so the byte offset is dropped.
    assign unused_fetch_low = &bus.i_addr[1:0];

    assign d_misaligned = (bus.d_addr[1:0] != 2'b00);
    assign rd_done      = (state == WAIT) && (lat_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        rd_start  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state)
            IDLE: begin
                // Data wins a tie unless fetch has already lost STARVE_MAX times in a row.
                if (rstn) begin
                    if (bus.d_req && !(bus.i_req && (starve_cnt == SCNT_W'(STARVE_MAX)))) begin
                        gnt_d = 1'b1;
                    end else if (bus.i_req) begin
                        gnt_i = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (rd_done) begin
                    state_nxt = IDLE;
                end
            end
        endcase

        if (gnt_d) begin
            mem_en    = !d_misaligned;
            mem_we    = bus.d_we && !d_misaligned;
            mem_addr  = bus.d_addr[ADDR_W-1:2];
            mem_wdata = bus.d_wdata;
            rd_start  = !bus.d_we && !d_misaligned;
        end else if (gnt_i) begin
            mem_en    = 1'b1;
            mem_addr  = bus.i_addr[ADDR_W-1:2];
            rd_start  = 1'b1;
        end

        if (rd_start) begin
            state_nxt = WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            d_err      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_rvalid <= rd_done && !owner_d;
            d_rvalid <= (rd_done && owner_d) || (gnt_d && d_misaligned && !bus.d_we);
            d_err    <= gnt_d && d_misaligned;

            if (rd_start) begin
                lat_cnt <= LAT_W'(MEM_LAT - 1);
                owner_d <= gnt_d;
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            // RAM data is valid in the last WAIT cycle; capture it for the port that owns the read.
            if (rd_done && !owner_d) begin
                i_rdata <= bus.mem_rdata;
            end
            if (rd_done && owner_d) begin
                d_rdata <= bus.mem_rdata;
            end else if (gnt_d && d_misaligned && !bus.d_we) begin
                d_rdata <= '0;
            end

            if (!bus.i_req || gnt_i) begin
                starve_cnt <= '0;
            end else if (gnt_d && (starve_cnt != SCNT_W'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign bus.i_gnt     = gnt_i;
    assign bus.d_gnt     = gnt_d;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_rvalid  = i_rvalid;
    assign bus.i_rdata   = i_rdata;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.d_rdata   = d_rdata;
    assign bus.d_err     = d_err;
    assign bus.busy      = (state == WAIT);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, timing and memory contents.
module tb_unified_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ML     = 2;
    localparam int SM     = 4;
    localparam int RAM_W  = 64;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        load;
        logic        err;
    } rsp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(ML), .STARVE_MAX(SM)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    req_t        iq[$];
    req_t        dq[$];
    rsp_t        i_exp[$];
    rsp_t        d_exp[$];
    logic [31:0] shadow [RAM_W];
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          next_free = 0;
    int          starve = 0;
    bit          init_done = 1'b0;
    bit          drop_mode = 1'b0;

    function automatic logic [31:0] init_word(input int k);
        return (k == 4) ? 32'h2008_0005 : (32'hA500_0000 ^ (32'(k) * 32'h0101_0101));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Single-port RAM with MEM_LAT read latency; junk on the read bus when no read is due.
    logic [31:0] ram  [RAM_W];
    logic [31:0] pipe [ML];
    bit          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int k = 0; k < RAM_W; k++) ram[k] <= init_word(k);
            ram_loaded <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            ram[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
        pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr[5:0]] : $urandom;
        for (int k = 1; k < ML; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_rdata = pipe[ML-1];

    task automatic push_i(input logic [31:0] a);
        req_t r;
        r.we = 1'b0; r.addr = a; r.wdata = '0;
        iq.push_back(r);
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        req_t r;
        r.we = we; r.addr = a; r.wdata = wd;
        dq.push_back(r);
    endtask

    // Requester engine: presents queue heads, holds them until granted.
    initial begin
        bit gi, gd;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        forever begin
            @(negedge clk);
            gi = bus.i_gnt;
            gd = bus.d_gnt;
            @(posedge clk);
            #1;
            if (gi && iq.size() > 0) void'(iq.pop_front());
            if (gd && dq.size() > 0) void'(dq.pop_front());
            bus.i_req = (iq.size() > 0) && !(drop_mode && $urandom_range(0, 7) == 0);
            if (iq.size() > 0) bus.i_addr = iq[0].addr;
            bus.d_req = (dq.size() > 0) && !(drop_mode && $urandom_range(0, 7) == 0);
            if (dq.size() > 0) begin
                bus.d_we    = dq[0].we;
                bus.d_addr  = dq[0].addr;
                bus.d_wdata = dq[0].wdata;
            end
        end
    end

    task automatic check_cycle();
        rsp_t e;
        bit   want_i, want_d, mis;
        int   w;

        if (bus.i_rvalid) begin
            if (i_exp.size() == 0) chk("i_rvalid_spurious", 1, 0);
            else begin
                e = i_exp.pop_front();
                chk("i_rvalid_cycle", cyc, e.cyc);
                chk("i_rdata", bus.i_rdata, e.data);
                last_i = e.data;
            end
        end else if (i_exp.size() > 0 && i_exp[0].cyc <= cyc) begin
            chk("i_rvalid_missing", 0, 1);
            void'(i_exp.pop_front());
        end

        if (bus.d_rvalid || bus.d_err) begin
            if (d_exp.size() == 0) chk("d_resp_spurious", 1, 0);
            else begin
                e = d_exp.pop_front();
                chk("d_resp_cycle", cyc, e.cyc);
                chk("d_rvalid", bus.d_rvalid, e.load);
                chk("d_err", bus.d_err, e.err);
                if (e.load) begin
                    chk("d_rdata", bus.d_rdata, e.data);
                    last_d = e.data;
                end
            end
        end else if (d_exp.size() > 0 && d_exp[0].cyc <= cyc) begin
            chk("d_resp_missing", 0, 1);
            void'(d_exp.pop_front());
        end

        chk("i_rdata_hold", bus.i_rdata, last_i);
        chk("d_rdata_hold", bus.d_rdata, last_d);
        chk("rvalid_both", bus.i_rvalid & bus.d_rvalid, 0);
        chk("busy", bus.busy, cyc < next_free);

        want_i = 1'b0;
        want_d = 1'b0;
        if (rstn && cyc >= next_free) begin
            if (bus.d_req && !(bus.i_req && starve == SM)) want_d = 1'b1;
            else if (bus.i_req) want_i = 1'b1;
        end
        chk("i_gnt", bus.i_gnt, want_i);
        chk("d_gnt", bus.d_gnt, want_d);

        mis = (bus.d_addr[1:0] != 2'b00);
        if (want_d) begin
            w = int'(bus.d_addr[7:2]);
            chk("d_mem_en", bus.mem_en, !mis);
            chk("d_mem_we", bus.mem_we, bus.d_we && !mis);
            if (!mis) chk("d_mem_addr", bus.mem_addr, bus.d_addr[31:2]);
            if (mis) begin
                e.cyc = cyc + 1; e.data = '0; e.load = !bus.d_we; e.err = 1'b1;
                d_exp.push_back(e);
                next_free = cyc + 1;
            end else if (bus.d_we) begin
                chk("d_mem_wdata", bus.mem_wdata, bus.d_wdata);
                shadow[w] = bus.d_wdata;
                next_free = cyc + 1;
            end else begin
                e.cyc = cyc + ML + 1; e.data = shadow[w]; e.load = 1'b1; e.err = 1'b0;
                d_exp.push_back(e);
                next_free = cyc + ML + 1;
            end
        end else if (want_i) begin
            chk("i_mem_en", bus.mem_en, 1);
            chk("i_mem_we", bus.mem_we, 0);
            chk("i_mem_addr", bus.mem_addr, bus.i_addr[31:2]);
            e.cyc = cyc + ML + 1; e.data = shadow[int'(bus.i_addr[7:2])]; e.load = 1'b1; e.err = 1'b0;
            i_exp.push_back(e);
            next_free = cyc + ML + 1;
        end else begin
            chk("idle_mem_en", bus.mem_en, 0);
            chk("idle_mem_we", bus.mem_we, 0);
        end

        if (!rstn || !bus.i_req || want_i) starve = 0;
        else if (want_d && starve < SM) starve++;

        if (!rstn) begin
            i_exp.delete();
            d_exp.delete();
            next_free = cyc + 1;
            last_i = '0;
            last_d = '0;
        end
    endtask

    // Monitor: scoreboard pops/compares every cycle, sampled on the falling edge.
    initial begin
        for (int k = 0; k < RAM_W; k++) shadow[k] = init_word(k);
        forever begin
            @(negedge clk);
            if (init_done) check_cycle();
            cyc++;
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || i_exp.size() > 0 || d_exp.size() > 0 ||
                cyc <= next_free) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", n >= budget, 0);
    endtask

    initial begin
        int          n;
        logic [31:0] a;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        init_done = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;

        push_i(32'h10);
        wait_idle(100);

        push_d(1'b1, 32'h8, 32'hDEADBEEF);
        push_d(1'b0, 32'h8, 32'h0);
        wait_idle(100);

        push_d(1'b0, 32'h6, 32'h0);
        push_d(1'b1, 32'h5, 32'h1234_5678);
        push_d(1'b0, 32'h4, 32'h0);
        wait_idle(100);

        repeat (10) push_i(32'h20);
        repeat (45) push_d(1'b0, 32'h40, 32'h0);
        wait_idle(1000);

        push_i(32'h31);
        push_i(32'h36);
        push_i(32'h3B);
        wait_idle(100);

        // Reset two cycles after a fetch grant; a second fetch waits across the reset.
        push_i(32'h14);
        push_i(32'h18);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.i_gnt && n < 50);
        chk("reset_case_grant_seen", bus.i_gnt, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        wait_idle(100);

        drop_mode = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            if (iq.size() < 2 && $urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 255);
                push_i(a);
            end
            if (dq.size() < 2 && $urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, 255);
                if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                push_d(1'($urandom_range(0, 1)), a, $urandom);
            end
            if ($urandom_range(0, 249) == 0) begin
                #1;
                rstn = 1'b0;
                @(posedge clk); #1;
                rstn = 1'b1;
            end
        end
        drop_mode = 1'b0;
        wait_idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule
